// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and constants for the cache refill controller.
package cache_refill_ctrl_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WEN_W     = 4;
  localparam int unsigned MEM_LEN_W = 5;
  localparam int unsigned PERF_W    = 32;
  localparam logic [WEN_W-1:0] WEN_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/refill_perf_cnt.sv
// Saturating miss and stall-cycle counters for the refill controller.
module refill_perf_cnt
  import cache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_inc,
  input  logic              stall_inc,
  output logic [PERF_W-1:0] perf_miss_cnt,
  output logic [PERF_W-1:0] perf_stall_cyc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_miss_cnt  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (miss_inc && (perf_miss_cnt != '1))
        perf_miss_cnt <= perf_miss_cnt + PERF_W'(1);
      if (stall_inc && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + PERF_W'(1);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss handler: stalls, fetches an aligned burst, refills the cache, forwards the critical word.
// Optional performance counters are enabled with `CACHE_REFILL_PERF_EN.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic                 miss,
  output logic                 stall,
  output logic                 cpu_rvalid,
  output logic [WORD_W-1:0]    cpu_rdata,
  output logic                 refill,
  output logic [ADDR_W-1:0]    addr_w,
  output logic [WORD_W-1:0]    data_w,
  output logic [WEN_W-1:0]     wen,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [MEM_LEN_W-1:0] mem_len,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [WORD_W-1:0]    mem_rdata,
  input  logic                 mem_rlast,
  output logic                 proto_err
`ifdef CACHE_REFILL_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_miss_cnt,
  output logic [PERF_W-1:0]    perf_stall_cyc
`endif
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   miss_addr_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                cpu_rvalid_q;
  logic [WORD_W-1:0]   cpu_rdata_q;
  logic                proto_err_q;

  logic                miss_start_c;
  logic                beat_c;
  logic                last_beat_c;
  logic [ADDR_W-1:0]   fill_addr_c;

  // Aligned base has zero offset bits, so OR-ing the count never carries out of the block.
  assign fill_addr_c  = base_q | ADDR_W'(cnt_q);
  assign last_beat_c  = (cnt_q == LAST_CNT);
  assign miss_start_c = !reset && (state_q == ST_IDLE) && cpu_req && miss;
  assign beat_c       = !reset && (state_q == ST_FILL) && mem_rvalid;

  assign stall      = miss_start_c || (!reset && (state_q != ST_IDLE));
  assign refill     = beat_c;
  assign addr_w     = beat_c ? fill_addr_c : '0;
  assign data_w     = beat_c ? mem_rdata : '0;
  assign wen        = beat_c ? WEN_FULL : '0;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_len    = MEM_LEN_W'(BURST_LEN);
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign proto_err  = proto_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req && miss) begin
            miss_addr_q <= cpu_addr;
            base_q      <= cpu_addr & ~OFS_MASK;
            mem_addr_q  <= cpu_addr & ~OFS_MASK;
            mem_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            if (fill_addr_c == miss_addr_q) begin
              cpu_rdata_q  <= mem_rdata;
              cpu_rvalid_q <= 1'b1;
            end
            // rlast must coincide exactly with the counted final beat.
            if (last_beat_c != mem_rlast)
              proto_err_q <= 1'b1;
            if (last_beat_c)
              state_q <= ST_DONE;
            else
              cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_REFILL_PERF_EN
  refill_perf_cnt u_perf (
    .clk            (clk),
    .reset          (reset),
    .miss_inc       (miss_start_c),
    .stall_inc      (stall),
    .perf_miss_cnt  (perf_miss_cnt),
    .perf_stall_cyc (perf_stall_cyc)
  );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: randomized misses, hits and protocol faults.
module tb_cache_refill_ctrl;

  localparam int unsigned BL = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        miss;
  logic        stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        refill;
  logic [31:0] addr_w;
  logic [31:0] data_w;
  logic [3:0]  wen;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [4:0]  mem_len;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        proto_err;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] perf_miss_cnt;
  logic [31:0] perf_stall_cyc;
`endif

  cache_refill_ctrl #(.BURST_LEN(BL), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .miss       (miss),
    .stall      (stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .refill     (refill),
    .addr_w     (addr_w),
    .data_w     (data_w),
    .wen        (wen),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_len    (mem_len),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rlast  (mem_rlast),
    .proto_err  (proto_err)
`ifdef CACHE_REFILL_PERF_EN
    ,
    .perf_miss_cnt  (perf_miss_cnt),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wr_t         exp_ref[$];
  wr_t         exp_crit[$];
  logic [31:0] exp_mem[$];
  bit          exp_perr = 1'b0;
  int          exp_miss = 0;
  longint      exp_stall_tot = 0;
  int          stall_cnt = 0;
  logic        prev_refill = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected at %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (stall) stall_cnt++;
      if (refill) begin
        if (exp_ref.size() == 0) unexpected("refill");
        else begin
          e = exp_ref.pop_front();
          check("refill_addr", 64'(addr_w), 64'(e.addr));
          check("refill_data", 64'(data_w), 64'(e.data));
          check("refill_wen", 64'(wen), 64'h0F);
        end
      end else if (wen != 4'h0) begin
        check("wen_idle", 64'(wen), 64'h0);
      end
      if (cpu_rvalid) begin
        if (exp_crit.size() == 0) unexpected("cpu_rvalid");
        else begin
          e = exp_crit.pop_front();
          check("crit_data", 64'(cpu_rdata), 64'(e.data));
          check("crit_timing", 64'(prev_refill && (prev_addr == e.addr)), 64'h1);
        end
      end
      if (mem_req && mem_gnt) begin
        if (exp_mem.size() == 0) unexpected("mem_req");
        else begin
          check("mem_addr", 64'(mem_addr), 64'(exp_mem.pop_front()));
          check("mem_len", 64'(mem_len), 64'(BL));
        end
      end
      prev_refill = refill;
      prev_addr   = addr_w;
    end else begin
      prev_refill = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hits(input int n);
    stall_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cpu_req    = 1'b1;
      miss       = 1'b0;
      cpu_addr   = $urandom;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      step();
    end
    cpu_req    = 1'b0;
    mem_rvalid = 1'b0;
    check("hit_no_stall", 64'(stall_cnt), 64'h0);
  endtask

  // One full miss; rlast_pos = BL-1 is a clean burst, anything else is a protocol fault.
  task automatic do_miss(input logic [31:0] addr, input int gdly, input bit gaps, input int rlast_pos);
    logic [31:0] base;
    logic [31:0] d [BL];
    int ngap = 0;
    longint exp_stall;
    base = addr & ~32'(BL - 1);
    for (int i = 0; i < int'(BL); i++) begin
      d[i] = $urandom;
      exp_ref.push_back('{addr: base + 32'(i), data: d[i]});
    end
    exp_crit.push_back('{addr: addr, data: d[addr - base]});
    exp_mem.push_back(base);
    if (rlast_pos != int'(BL) - 1) exp_perr = 1'b1;
    stall_cnt = 0;
    cpu_req  = 1'b1;
    miss     = 1'b1;
    cpu_addr = addr;
    step();
    cpu_req  = 1'($urandom_range(0, 1));
    miss     = 1'($urandom_range(0, 1));
    cpu_addr = $urandom;
    check("mem_req_held", 64'(mem_req), 64'h1);
    repeat (gdly) step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < int'(BL); i++) begin
      while (gaps && ($urandom_range(0, 2) == 0)) begin
        ngap++;
        step();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = d[i];
      mem_rlast  = (i == rlast_pos);
      step();
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
    end
    cpu_req = 1'b0;
    miss    = 1'b0;
    step();
    exp_stall = 64'(3 + gdly + int'(BL) + ngap);
    check("stall_len", 64'(stall_cnt), 64'(exp_stall));
    check("proto_err", 64'(proto_err), 64'(exp_perr));
    check("mem_req_drop", 64'(mem_req), 64'h0);
    exp_miss++;
    exp_stall_tot += exp_stall;
  endtask

  // Reset after two beats of a burst whose critical word would have been beat 3.
  task automatic do_reset_mid();
    logic [31:0] base;
    base = $urandom & ~32'(BL - 1);
    exp_mem.push_back(base);
    cpu_req  = 1'b1;
    miss     = 1'b1;
    cpu_addr = base + 32'(BL - 1);
    step();
    cpu_req = 1'b0;
    miss    = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      exp_ref.push_back('{addr: base + 32'(i), data: mem_rdata});
      step();
    end
    reset     = 1'b1;
    mem_rdata = $urandom;
    step();
    reset = 1'b0;
    exp_perr = 1'b0;
    exp_miss = 0;
    exp_stall_tot = 0;
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    mem_rdata = $urandom;
    mem_rlast = 1'b1;
    step();
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    check("rst_proto_err", 64'(proto_err), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    miss       = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_rlast  = 1'b0;
    repeat (3) step();
    check("rst_stall0", 64'(stall), 64'h0);
    check("rst_rvalid0", 64'(cpu_rvalid), 64'h0);
    check("rst_rdata0", 64'(cpu_rdata), 64'h0);
    check("rst_refill0", 64'(refill), 64'h0);
    check("rst_addr_w0", 64'(addr_w), 64'h0);
    check("rst_data_w0", 64'(data_w), 64'h0);
    check("rst_wen0", 64'(wen), 64'h0);
    check("rst_mem_req0", 64'(mem_req), 64'h0);
    check("rst_mem_addr0", 64'(mem_addr), 64'h0);
    check("rst_proto_err0", 64'(proto_err), 64'h0);
    reset = 1'b0;
    step();

    do_miss(32'h103, 2, 1'b0, int'(BL) - 1);
    do_hits(1);
    do_miss(32'h201, 1, 1'b1, int'(BL) - 1);
    do_hits(2);
    do_miss(32'h305, 0, 1'b0, 1);
    do_hits(2);
    do_reset_mid();
    do_hits(5);
    do_miss(32'h4002, 0, 1'b0, int'(BL) - 1);
    do_hits(1);
    do_miss($urandom, 3, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      int rp;
      rp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BL)) - 1 : int'(BL) - 1;
      do_hits(int'($urandom_range(0, 4)));
      do_miss($urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), rp);
    end
    do_hits(3);

`ifdef CACHE_REFILL_PERF_EN
    check("perf_miss_cnt", 64'(perf_miss_cnt), 64'(exp_miss));
    check("perf_stall_cyc", 64'(perf_stall_cyc), 64'(exp_stall_tot));
`endif
    check("refill_queue_empty", 64'(exp_ref.size()), 64'h0);
    check("crit_queue_empty", 64'(exp_crit.size()), 64'h0);
    check("mem_queue_empty", 64'(exp_mem.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
